apb_irq_service_master: RTL
===========================

Name: apb_irq_service_master

Overview:
APB initiator that services the 4-source APB interrupt controller from the bus side. On interrupt it reads the status register, writes the same bits to the clear register, then rewrites the mask register from a shadow copy, because clear also zeroes mask bits. It also forwards host mask-configuration requests as APB writes. It sits between a simple host/CPU-side request interface and the controller's APB slave port.

Parameters:
NUM_IRQ, 4, number of interrupt sources and the status/clear/mask width.
ADDR_STATUS, 1, APB address of the status register (read).
ADDR_CLEAR, 2, APB address of the clear register (write).
ADDR_MASK, 3, APB address of the mask register (write).
HOLDOFF_CYCLES, 3, idle cycles after a sequence before irq_i is sampled again; covers clear→status→interrupt latency.
TIMEOUT_CYCLES, 16, maximum ACCESS-phase cycles waiting for pready_i before abort.

Ports:
pclk_i  in  1  clock
rst_n_i  in  1  reset, asynchronous, active-low
psel_o  out  1  APB select
penable_o  out  1  APB enable
pwrite_o  out  1  APB write (1) / read (0)
paddr_o  out  32  APB address
pwdata_o  out  32  APB write data
prdata_i  in  32  APB read data
pready_i  in  1  APB ready
pslverr_i  in  1  APB slave error
irq_i  in  1  interrupt from controller
cfg_valid_i  in  1  host mask-write request
cfg_mask_i  in  NUM_IRQ  requested mask value
cfg_ready_o  out  1  request accepted when valid&ready
svc_valid_o  out  1  one-cycle pulse: service sequence done
svc_status_o  out  NUM_IRQ  status bits serviced; held until next svc_valid_o
err_o  out  1  one-cycle pulse: pslverr or timeout abort

Behaviour:
- Reset: all outputs 0, shadow mask 0, state IDLE, counters 0. Async reset mid-transfer drops psel_o/penable_o immediately. No resume after reset.
- States: IDLE, SETUP, ACCESS, HOLDOFF. Op register selects RD_STATUS, WR_CLEAR, or WR_MASK.
- cfg_ready_o = (state==IDLE), combinational.
- IDLE priority: cfg_valid_i first. Accept, shadow_mask <= cfg_mask_i, op=WR_MASK, go to SETUP, no svc pulse on completion. Otherwise irq_i=1: op=RD_STATUS, go to SETUP.
- SETUP (1 cycle): psel_o=1, penable_o=0. paddr_o, pwrite_o, and pwdata_o are valid and held stable through ACCESS. Upper pwdata bits are 0.
- ACCESS: psel_o=1, penable_o=1. Hold until pready_i.
- On pready_i & ~pslverr_i:
  - RD_STATUS: capture prdata_i[NUM_IRQ-1:0]. If 0 (spurious): svc_valid_o with status 0, go to HOLDOFF. Else next op WR_CLEAR (pwdata=captured status).
  - WR_CLEAR: next op WR_MASK (pwdata=shadow_mask).
  - WR_MASK in a service sequence: svc_valid_o pulse, svc_status_o=captured status, go to HOLDOFF.
  - WR_MASK for a config request: go to IDLE.
- Back-to-back ops: the next op enters SETUP on the cycle after completion. psel_o stays 1 and penable_o drops to 0.
- pslverr_i with pready_i: err_o pulse, abort sequence, psel_o=0, go to HOLDOFF. No svc pulse.
- Timeout: wait counter counts ACCESS cycles with pready_i=0. Reaching TIMEOUT_CYCLES gives err_o pulse, psel_o/penable_o=0, go to HOLDOFF.
- HOLDOFF: count HOLDOFF_CYCLES, then IDLE. irq_i and cfg_valid_i are ignored (cfg_ready_o=0).
- Minimum service latency with pready_i=1: 6 cycles (3 transfers × 2). svc_valid_o is asserted in the cycle after the WR_MASK access completes.

Optional Feature:
Macro IRQ_SVC_STATS_EN.
- Defined: adds output svc_count_o (16 bits). It is a saturating count of non-spurious services, resets to 0 and holds at 16'hFFFF.
- Undefined: port and counter absent; other behaviour identical.

Decomposition:
- Package apb_irq_pkg holds:
  - state enum (IDLE/SETUP/ACCESS/HOLDOFF)
  - op enum (RD_STATUS/WR_CLEAR/WR_MASK)
  - register address constants shared with the controller.
- Sub-module apb_master_phy: SETUP/ACCESS sequencing, timeout counter, and done/err strobes. The top holds the op sequencer and shadow mask.

Test Plan:
- Reset, then cfg_mask_i=4'b0101 with cfg_valid_i → one write: paddr=3, pwdata=5. Controller mask=0101. No svc_valid_o.
- Mask 4'b1111, pulse irq_trigger[2] → read addr 1 (prdata=4), write addr 2 data 4, write addr 3 data 15. svc_valid_o with svc_status_o=4'b0100. Controller interrupt returns to 0 within HOLDOFF.
- Spurious: irq_i forced 1, status 0 → single read. svc_valid_o with status 0. No writes issued.
- cfg_valid_i and irq_i rise in the same cycle → mask write runs first, then the service sequence, whose WR_MASK uses the new mask.
- pready_i held 0 for 20 cycles → err_o at ACCESS cycle 16, psel_o drops, HOLDOFF, then IDLE. Separately, pslverr_i on WR_CLEAR → err_o, no WR_MASK issued.
- rst_n_i asserted during ACCESS of WR_CLEAR → psel_o=0 immediately, all outputs 0. After release, the first transfer starts from IDLE.

Source files
------------

// File: rtl/apb_irq_pkg.sv
// Shared types and register map for the APB interrupt-controller service master.
package apb_irq_pkg;

    localparam int unsigned APB_AW = 32;
    localparam int unsigned APB_DW = 32;

    // Register map of the 4-source interrupt controller
    localparam logic [APB_AW-1:0] REG_ADDR_STATUS = 32'd1;
    localparam logic [APB_AW-1:0] REG_ADDR_CLEAR  = 32'd2;
    localparam logic [APB_AW-1:0] REG_ADDR_MASK   = 32'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        ACCESS  = 2'd2,
        HOLDOFF = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        RD_STATUS = 2'd0,
        WR_CLEAR  = 2'd1,
        WR_MASK   = 2'd2
    } op_t;

endpackage

// File: rtl/apb_irq_service_master_if.sv
// APB bus between the service master (initiator) and the interrupt controller (completer).
interface apb_irq_service_master_if;
    import apb_irq_pkg::*;

    logic              psel_o;
    logic              penable_o;
    logic              pwrite_o;
    logic [APB_AW-1:0] paddr_o;
    logic [APB_DW-1:0] pwdata_o;
    logic [APB_DW-1:0] prdata_i;
    logic              pready_i;
    logic              pslverr_i;

    modport master (
        output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o,
        input  prdata_i, pready_i, pslverr_i
    );

    modport slave (
        input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o,
        output prdata_i, pready_i, pslverr_i
    );

endinterface

// File: rtl/apb_master_phy.sv
// APB SETUP/ACCESS sequencer with ACCESS-phase timeout; accepts a back-to-back request
// in the completion cycle and reports done/err strobes combinationally.
module apb_master_phy
    import apb_irq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              pclk_i,
    input  logic              rst_n_i,
    input  logic              req_i,
    input  logic              req_write_i,
    input  logic [APB_AW-1:0] req_addr_i,
    input  logic [APB_DW-1:0] req_wdata_i,
    output state_t            state_o,
    output logic              done_o,
    output logic              err_o,
    apb_irq_service_master_if.master apb
);

    localparam int unsigned       CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q;
    logic [CNT_W-1:0] wait_cnt_q;
    logic             in_access;
    logic             timeout;

    assign in_access = (state_q == ACCESS);
    assign timeout   = in_access & ~apb.pready_i & (wait_cnt_q == LAST_WAIT);
    assign done_o    = in_access & apb.pready_i & ~apb.pslverr_i;
    assign err_o     = in_access & ((apb.pready_i & apb.pslverr_i) | timeout);
    assign state_o   = state_q;

    // NOTE: clocked state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge pclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= IDLE;
            wait_cnt_q    <= '0;
            apb.psel_o    <= 1'b0;
            apb.penable_o <= 1'b0;
            apb.pwrite_o  <= 1'b0;
            apb.paddr_o   <= '0;
            apb.pwdata_o  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_i) begin
                        apb.psel_o   <= 1'b1;
                        apb.pwrite_o <= req_write_i;
                        apb.paddr_o  <= req_addr_i;
                        apb.pwdata_o <= req_wdata_i;
                        state_q      <= SETUP;
                    end
                end
                SETUP: begin
                    apb.penable_o <= 1'b1;
                    wait_cnt_q    <= '0;
                    state_q       <= ACCESS;
                end
                ACCESS: begin
                    if (apb.pready_i) begin
                        apb.penable_o <= 1'b0;
                        // A follow-on request keeps psel high and goes straight to SETUP
                        if (done_o && req_i) begin
                            apb.pwrite_o <= req_write_i;
                            apb.paddr_o  <= req_addr_i;
                            apb.pwdata_o <= req_wdata_i;
                            state_q      <= SETUP;
                        end else begin
                            apb.psel_o <= 1'b0;
                            state_q    <= IDLE;
                        end
                    end else if (timeout) begin
                        apb.psel_o    <= 1'b0;
                        apb.penable_o <= 1'b0;
                        state_q       <= IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/apb_irq_service_master.sv
// Services the APB interrupt controller: read status, clear it, restore mask from shadow;
// forwards host mask writes. Optional saturating service counter under IRQ_SVC_STATS_EN.
module apb_irq_service_master
    import apb_irq_pkg::*;
#(
    parameter int unsigned       NUM_IRQ        = 4,
    parameter logic [APB_AW-1:0] ADDR_STATUS    = REG_ADDR_STATUS,
    parameter logic [APB_AW-1:0] ADDR_CLEAR     = REG_ADDR_CLEAR,
    parameter logic [APB_AW-1:0] ADDR_MASK      = REG_ADDR_MASK,
    parameter int unsigned       HOLDOFF_CYCLES = 3,
    parameter int unsigned       TIMEOUT_CYCLES = 16
) (
    input  logic               pclk_i,
    input  logic               rst_n_i,
    apb_irq_service_master_if.master apb,
    input  logic               irq_i,
    input  logic               cfg_valid_i,
    input  logic [NUM_IRQ-1:0] cfg_mask_i,
    output logic               cfg_ready_o,
    output logic               svc_valid_o,
    output logic [NUM_IRQ-1:0] svc_status_o,
    output logic               err_o
`ifdef IRQ_SVC_STATS_EN
    ,
    output logic [15:0]        svc_count_o
`endif
);

    localparam int unsigned      HOLD_W    = $clog2(HOLDOFF_CYCLES + 2);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLDOFF_CYCLES);

    op_t                op_q;
    logic               cfg_seq_q;
    logic [NUM_IRQ-1:0] shadow_mask_q;
    logic [NUM_IRQ-1:0] status_q;
    logic [HOLD_W-1:0]  hold_cnt_q;

    state_t             phy_state;
    state_t             state;
    logic               phy_done;
    logic               phy_err;
    logic [NUM_IRQ-1:0] rd_status;
    logic               svc_done;

    logic               req;
    logic               req_write;
    logic [APB_AW-1:0]  req_addr;
    logic [APB_DW-1:0]  req_wdata;

    assign state       = (hold_cnt_q != '0) ? HOLDOFF : phy_state;
    assign cfg_ready_o = (state == IDLE);
    assign rd_status   = apb.prdata_i[NUM_IRQ-1:0];
    assign svc_done    = phy_done & (op_q == WR_MASK) & ~cfg_seq_q;

    // NOTE: every output gets a default first so this decode never infers a latch.
    always_comb begin
        req       = 1'b0;
        req_write = 1'b0;
        req_addr  = ADDR_STATUS;
        req_wdata = '0;
        if (cfg_ready_o) begin
            if (cfg_valid_i) begin
                req       = 1'b1;
                req_write = 1'b1;
                req_addr  = ADDR_MASK;
                req_wdata = APB_DW'(cfg_mask_i);
            end else if (irq_i) begin
                req = 1'b1;
            end
        end else if (phy_done) begin
            case (op_q)
                RD_STATUS: begin
                    if (rd_status != '0) begin
                        req       = 1'b1;
                        req_write = 1'b1;
                        req_addr  = ADDR_CLEAR;
                        req_wdata = APB_DW'(rd_status);
                    end
                end
                // Clearing also zeroes mask bits, so the mask is rewritten from the shadow copy
                WR_CLEAR: begin
                    req       = 1'b1;
                    req_write = 1'b1;
                    req_addr  = ADDR_MASK;
                    req_wdata = APB_DW'(shadow_mask_q);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge pclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            op_q          <= RD_STATUS;
            cfg_seq_q     <= 1'b0;
            shadow_mask_q <= '0;
            status_q      <= '0;
            hold_cnt_q    <= '0;
            svc_valid_o   <= 1'b0;
            svc_status_o  <= '0;
            err_o         <= 1'b0;
        end else begin
            svc_valid_o <= 1'b0;
            err_o       <= 1'b0;
            if (hold_cnt_q != '0) begin
                hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
            end

            if (cfg_ready_o) begin
                if (cfg_valid_i) begin
                    shadow_mask_q <= cfg_mask_i;
                    op_q          <= WR_MASK;
                    cfg_seq_q     <= 1'b1;
                end else if (irq_i) begin
                    op_q      <= RD_STATUS;
                    cfg_seq_q <= 1'b0;
                end
            end

            if (phy_err) begin
                err_o      <= 1'b1;
                hold_cnt_q <= HOLD_INIT;
            end else if (phy_done) begin
                case (op_q)
                    RD_STATUS: begin
                        if (rd_status == '0) begin
                            svc_valid_o  <= 1'b1;
                            svc_status_o <= '0;
                            hold_cnt_q   <= HOLD_INIT;
                        end else begin
                            status_q <= rd_status;
                            op_q     <= WR_CLEAR;
                        end
                    end
                    WR_CLEAR: op_q <= WR_MASK;
                    WR_MASK: begin
                        if (!cfg_seq_q) begin
                            svc_valid_o  <= 1'b1;
                            svc_status_o <= status_q;
                            hold_cnt_q   <= HOLD_INIT;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef IRQ_SVC_STATS_EN
    always_ff @(posedge pclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            svc_count_o <= '0;
        end else if (svc_done && svc_count_o != 16'hFFFF) begin
            svc_count_o <= svc_count_o + 16'd1;
        end
    end
`else
    logic unused_svc_done;
    assign unused_svc_done = svc_done;
`endif

    apb_master_phy #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_phy (
        .pclk_i      (pclk_i),
        .rst_n_i     (rst_n_i),
        .req_i       (req),
        .req_write_i (req_write),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .state_o     (phy_state),
        .done_o      (phy_done),
        .err_o       (phy_err),
        .apb         (apb)
    );

endmodule
